// File: rtl/avalon_l15_burst_bridge_if.sv
// Avalon-MM command bus and L1.5 request/response bus seen by the bridge.
// slave: the bridge side; master: the core + L1.5 environment side.
interface avalon_l15_burst_bridge_if #(
  parameter int ADDR_W    = 30,
  parameter int MAX_BURST = 4,
  parameter int PA_W      = 40
);
  localparam int BC_W = $clog2(MAX_BURST) + 1;

  logic [ADDR_W-1:0] avm_address;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [BC_W-1:0]   avm_burstcount;
  logic              avm_write;
  logic              avm_read;
  logic              avm_waitrequest;
  logic              avm_readdatavalid;
  logic [31:0]       avm_readdata;

  logic              l15_val;
  logic [4:0]        l15_rqtype;
  logic [2:0]        l15_size;
  logic [PA_W-1:0]   l15_address;
  logic [63:0]       l15_data;
  logic              l15_nc;
  logic              l15_ack;
  logic              l15_rsp_val;
  logic [3:0]        l15_returntype;
  logic [63:0]       l15_data_0;
  logic [63:0]       l15_data_1;
  logic              l15_req_ack;
  logic              int_pulse;
  logic              err_pulse;

  modport slave (
    input  avm_address, avm_writedata, avm_byteenable,
    input  avm_burstcount, avm_write, avm_read,
    output avm_waitrequest, avm_readdatavalid, avm_readdata,
    output l15_val, l15_rqtype, l15_size, l15_address,
    output l15_data, l15_nc,
    input  l15_ack, l15_rsp_val, l15_returntype,
    input  l15_data_0, l15_data_1,
    output l15_req_ack, int_pulse, err_pulse
  );

  modport master (
    output avm_address, avm_writedata, avm_byteenable,
    output avm_burstcount, avm_write, avm_read,
    input  avm_waitrequest, avm_readdatavalid, avm_readdata,
    input  l15_val, l15_rqtype, l15_size, l15_address,
    input  l15_data, l15_nc,
    output l15_ack, l15_rsp_val, l15_returntype,
    output l15_data_0, l15_data_1,
    input  l15_req_ack, int_pulse, err_pulse
  );
endinterface

// File: rtl/avalon_l15_burst_bridge.sv
// Avalon-MM to L1.5 bridge: unrolls bursts into single-word
// loads/stores, one outstanding request at a time.
module avalon_l15_burst_bridge #(
  parameter int ADDR_W    = 30,
  parameter int MAX_BURST = 4,
  parameter int NC_BIT    = 29,
  parameter int BSWAP     = 1,
  parameter int PA_W      = 40
) (
  input logic clk,
  input logic rst_n,
  avalon_l15_burst_bridge_if.slave bus
);
  localparam int BC_W = $clog2(MAX_BURST) + 1;
  localparam int EXT  = PA_W - ADDR_W - 2;

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;
  localparam logic [2:0] SZ_1B    = 3'b000;
  localparam logic [2:0] SZ_2B    = 3'b001;
  localparam logic [2:0] SZ_4B    = 3'b010;
  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK   = 4'b0100;
  localparam logic [3:0] INT_RET  = 4'b0111;

  typedef enum logic [2:0] {
    IDLE, W_REQ, W_RSP, R_REQ, R_RSP
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] base_q, base_nx;
  logic [BC_W-1:0]   rem_q, rem_nx;
  logic [BC_W-1:0]   idx_q, idx_nx;
  logic [31:0]       rd_q, rd_nx;
  logic              int_q, int_nx;
  logic              err_q, err_nx;

  logic [ADDR_W-1:0] beat_addr;
  logic [ADDR_W+1:0] byte_addr;
  logic [BC_W-1:0]   bc;
  logic              bc_big;
  logic [BC_W-1:0]   rem_init;
  logic [2:0]        be_sz;
  logic [1:0]        be_off;
  logic              be_bad;
  logic [31:0]       wd;
  logic [31:0]       rd_word;
  logic              is_ld, is_st, is_int;
  logic              wr_req, val, rdv, wait_c;
  logic              stray, cmd_err, beat_err;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign beat_addr = base_q + ADDR_W'(idx_q);
  assign bc        = bus.avm_burstcount;
  assign bc_big    = bc > BC_W'(MAX_BURST);
  assign rem_init  = bc_big ? BC_W'(MAX_BURST - 1) :
                     (bc == '0) ? '0 : bc - 1'b1;

  assign is_ld  = bus.l15_returntype == LOAD_RET;
  assign is_st  = bus.l15_returntype == ST_ACK;
  assign is_int = bus.l15_returntype == INT_RET;

  assign wd = (BSWAP != 0) ? bswap(bus.avm_writedata)
                           : bus.avm_writedata;

  // Byte lanes to an exact transfer size and offset.
  always_comb begin
    be_sz  = SZ_4B;
    be_off = 2'd0;
    be_bad = 1'b0;
    unique case (1'b1)
      bus.avm_byteenable == 4'b0001: begin
        be_sz = SZ_1B; be_off = 2'd0;
      end
      bus.avm_byteenable == 4'b0010: begin
        be_sz = SZ_1B; be_off = 2'd1;
      end
      bus.avm_byteenable == 4'b0100: begin
        be_sz = SZ_1B; be_off = 2'd2;
      end
      bus.avm_byteenable == 4'b1000: begin
        be_sz = SZ_1B; be_off = 2'd3;
      end
      bus.avm_byteenable == 4'b0011: begin
        be_sz = SZ_2B; be_off = 2'd0;
      end
      bus.avm_byteenable == 4'b1100: begin
        be_sz = SZ_2B; be_off = 2'd2;
      end
      bus.avm_byteenable == 4'b1111: begin
        be_sz = SZ_4B; be_off = 2'd0;
      end
      default: be_bad = 1'b1;
    endcase
  end

  // Pick the addressed word of the returned 16-byte line.
  always_comb begin
    rd_word = '0;
    unique case (beat_addr[1:0])
      2'b00: rd_word = bus.l15_data_0[63:32];
      2'b01: rd_word = bus.l15_data_0[31:0];
      2'b10: rd_word = bus.l15_data_1[63:32];
      2'b11: rd_word = bus.l15_data_1[31:0];
      default: rd_word = '0;
    endcase
    if (BSWAP != 0) rd_word = bswap(rd_word);
  end

  // Next state, beat bookkeeping and handshake strobes.
  always_comb begin
    state_nx = state;
    base_nx  = base_q;
    rem_nx   = rem_q;
    idx_nx   = idx_q;
    rd_nx    = rd_q;
    wait_c   = 1'b1;
    rdv      = 1'b0;
    val      = 1'b0;
    wr_req   = 1'b0;
    cmd_err  = 1'b0;
    beat_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.avm_read) begin
          wait_c   = 1'b0;
          base_nx  = bus.avm_address;
          rem_nx   = rem_init;
          idx_nx   = '0;
          cmd_err  = bc_big;
          state_nx = R_REQ;
        end else if (bus.avm_write) begin
          base_nx  = bus.avm_address;
          rem_nx   = rem_init;
          idx_nx   = '0;
          cmd_err  = bc_big;
          state_nx = W_REQ;
        end
      end
      W_REQ: begin
        val    = 1'b1;
        wr_req = 1'b1;
        if (bus.l15_ack) begin
          beat_err = be_bad;
          state_nx = W_RSP;
        end
      end
      W_RSP: begin
        if (bus.l15_rsp_val && is_st) begin
          wait_c = 1'b0;
          if (rem_q == '0) begin
            state_nx = IDLE;
          end else begin
            rem_nx   = rem_q - 1'b1;
            idx_nx   = idx_q + 1'b1;
            state_nx = W_REQ;
          end
        end
      end
      R_REQ: begin
        val = 1'b1;
        if (bus.l15_ack) state_nx = R_RSP;
      end
      R_RSP: begin
        if (bus.l15_rsp_val && is_ld) begin
          rdv   = 1'b1;
          rd_nx = rd_word;
          if (rem_q == '0) begin
            state_nx = IDLE;
          end else begin
            rem_nx   = rem_q - 1'b1;
            idx_nx   = idx_q + 1'b1;
            state_nx = R_REQ;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    stray  = bus.l15_rsp_val &&
             ((is_ld && state != R_RSP) ||
              (is_st && state != W_RSP));
    err_nx = stray | cmd_err | beat_err;
    int_nx = bus.l15_rsp_val && is_int &&
             bus.l15_data_0[17:16] == 2'b01;
  end

  // State, burst context, held read data and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      base_q <= '0;
      rem_q  <= '0;
      idx_q  <= '0;
      rd_q   <= '0;
      int_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      base_q <= base_nx;
      rem_q  <= rem_nx;
      idx_q  <= idx_nx;
      rd_q   <= rd_nx;
      int_q  <= int_nx;
      err_q  <= err_nx;
    end
  end

  assign byte_addr = {beat_addr, wr_req ? be_off : 2'd0};

  assign bus.avm_waitrequest   = rst_n ? wait_c : 1'b1;
  assign bus.avm_readdatavalid = rst_n & rdv;
  assign bus.avm_readdata      = (rst_n & rdv) ? rd_word : rd_q;

  assign bus.l15_val     = rst_n & val;
  assign bus.l15_rqtype  = (rst_n & wr_req) ? STORE_RQ : LOAD_RQ;
  assign bus.l15_size    = !(rst_n & val) ? 3'b000 :
                           wr_req ? be_sz : SZ_4B;
  assign bus.l15_address = (rst_n & val) ?
    {{EXT{byte_addr[ADDR_W+1]}}, byte_addr} : '0;
  assign bus.l15_data    = (rst_n & wr_req) ? {wd, wd} : '0;
  assign bus.l15_nc      = rst_n & val & beat_addr[NC_BIT];
  assign bus.l15_req_ack = rst_n & bus.l15_rsp_val;
  assign bus.int_pulse   = int_q;
  assign bus.err_pulse   = err_q;
endmodule

// File: tb/tb_avalon_l15_burst_bridge.sv
// Bench for avalon_l15_burst_bridge: directed cases plus random
// bursts checked against a transaction-level reference model.
module tb_avalon_l15_burst_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avalon_l15_burst_bridge_if bus();

  avalon_l15_burst_bridge dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int wl_cnt = 0;
  int err_cnt = 0;
  int int_cnt = 0;
  int exp_err = 0;
  int exp_int = 0;

  // Event counters observed at each active edge.
  always @(posedge clk) begin
    if (!bus.avm_waitrequest) wl_cnt <= wl_cnt + 1;
    if (bus.err_pulse) err_cnt <= err_cnt + 1;
    if (bus.int_pulse) int_cnt <= int_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rev(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
    return r;
  endfunction

  function automatic int eff_beats(input int bc);
    if (bc == 0) return 1;
    if (bc > 4) return 4;
    return bc;
  endfunction

  function automatic void be_model(input logic [3:0] be,
                                   output logic [2:0] sz,
                                   output logic [1:0] off,
                                   output bit bad);
    int n;
    int lo;
    n = 0;
    lo = 4;
    for (int i = 0; i < 4; i++)
      if (be[i]) begin
        n++;
        if (lo == 4) lo = i;
      end
    sz = 3'b010;
    off = 2'd0;
    bad = 1'b0;
    if (n == 1) begin
      sz = 3'b000;
      off = 2'(lo);
    end else if (n == 2 && (lo == 0 || lo == 2) && be[lo+1]) begin
      sz = 3'b001;
      off = 2'(lo);
    end else if (n != 4) begin
      bad = 1'b1;
    end
  endfunction

  function automatic logic [39:0] exp_addr(input logic [29:0] w,
                                           input logic [1:0] off);
    logic [39:0] r;
    r = 40'(w) * 40'd4 + 40'(off);
    if (w[29]) r = r + 40'hFF_0000_0000;
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [29:0] w,
                                         input logic [63:0] d0,
                                         input logic [63:0] d1);
    logic [127:0] line;
    int k;
    line = {d0, d1};
    k = int'(w[1:0]);
    return rev(line[127-32*k -: 32]);
  endfunction

  task automatic wait_val(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.l15_val === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("val_timeout", 64'(bus.l15_val), 64'd1);
  endtask

  task automatic settle_counts(input string tag);
    tick();
    tick();
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    check({tag, "_int_cnt"}, 64'(int_cnt), 64'(exp_int));
  endtask

  task automatic do_write(input logic [29:0] addr, input int bc,
                          input int lat, input logic [3:0] be_fix,
                          input bit rnd_be);
    int n;
    int wl0;
    logic [31:0] wd;
    logic [3:0] be;
    logic [2:0] sz;
    logic [1:0] off;
    logic [29:0] w;
    bit bad;
    bit ok;
    n = eff_beats(bc);
    if (bc > 4) exp_err++;
    wl0 = wl_cnt;
    be = rnd_be ? 4'($urandom_range(0, 15)) : be_fix;
    wd = $urandom;
    bus.avm_write = 1'b1;
    bus.avm_address = addr;
    bus.avm_burstcount = 3'(bc);
    bus.avm_writedata = wd;
    bus.avm_byteenable = be;
    for (int i = 0; i < n; i++) begin
      wait_val(ok);
      if (!ok) begin
        bus.avm_write = 1'b0;
        return;
      end
      be_model(be, sz, off, bad);
      if (bad) exp_err++;
      w = addr + 30'(i);
      check("wr_rqtype", 64'(bus.l15_rqtype), 64'h01);
      check("wr_size", 64'(bus.l15_size), 64'(sz));
      check("wr_addr", 64'(bus.l15_address), 64'(exp_addr(w, off)));
      check("wr_data", bus.l15_data, {rev(wd), rev(wd)});
      check("wr_nc", 64'(bus.l15_nc), 64'(w[29]));
      bus.l15_ack = 1'b1;
      tick();
      bus.l15_ack = 1'b0;
      check("wr_val_drop", 64'(bus.l15_val), 64'd0);
      repeat (lat) tick();
      bus.l15_rsp_val = 1'b1;
      bus.l15_returntype = 4'b0100;
      bus.l15_data_0 = {$urandom, $urandom};
      #1;
      check("wr_wait_low", 64'(bus.avm_waitrequest), 64'd0);
      check("wr_req_ack", 64'(bus.l15_req_ack), 64'd1);
      tick();
      bus.l15_rsp_val = 1'b0;
      if (i == n - 1) begin
        bus.avm_write = 1'b0;
      end else begin
        be = rnd_be ? 4'($urandom_range(0, 15)) : be_fix;
        wd = $urandom;
        bus.avm_writedata = wd;
        bus.avm_byteenable = be;
      end
    end
    check("wr_accept_cnt", 64'(wl_cnt - wl0), 64'(n));
    settle_counts("wr");
  endtask

  task automatic do_read(input logic [29:0] addr, input int bc,
                         input int lat, input int int_code,
                         input bit fix, input logic [63:0] d0_fix);
    int n;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [63:0] di;
    logic [31:0] exp;
    logic [29:0] w;
    bit ok;
    n = eff_beats(bc);
    if (bc > 4) exp_err++;
    bus.avm_read = 1'b1;
    bus.avm_address = addr;
    bus.avm_burstcount = 3'(bc);
    #1;
    check("rd_cmd_wait", 64'(bus.avm_waitrequest), 64'd0);
    tick();
    bus.avm_read = 1'b0;
    for (int i = 0; i < n; i++) begin
      wait_val(ok);
      if (!ok) return;
      w = addr + 30'(i);
      check("rd_rqtype", 64'(bus.l15_rqtype), 64'h00);
      check("rd_size", 64'(bus.l15_size), 64'h2);
      check("rd_addr", 64'(bus.l15_address), 64'(exp_addr(w, 2'd0)));
      check("rd_nc", 64'(bus.l15_nc), 64'(w[29]));
      bus.l15_ack = 1'b1;
      tick();
      bus.l15_ack = 1'b0;
      repeat (lat) tick();
      if (i == 0 && int_code >= 0) begin
        di = {$urandom, $urandom};
        di[17:16] = 2'(int_code);
        bus.l15_rsp_val = 1'b1;
        bus.l15_returntype = 4'b0111;
        bus.l15_data_0 = di;
        #1;
        check("int_req_ack", 64'(bus.l15_req_ack), 64'd1);
        check("int_no_rdv", 64'(bus.avm_readdatavalid), 64'd0);
        tick();
        bus.l15_rsp_val = 1'b0;
        if (int_code == 1) exp_int++;
        tick();
      end
      d0 = fix ? d0_fix : {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      exp = exp_rd(w, d0, d1);
      bus.l15_rsp_val = 1'b1;
      bus.l15_returntype = 4'b0000;
      bus.l15_data_0 = d0;
      bus.l15_data_1 = d1;
      #1;
      check("rd_valid", 64'(bus.avm_readdatavalid), 64'd1);
      check("rd_data", 64'(bus.avm_readdata), 64'(exp));
      check("rd_req_ack", 64'(bus.l15_req_ack), 64'd1);
      tick();
      bus.l15_rsp_val = 1'b0;
      #1;
      check("rd_valid_drop", 64'(bus.avm_readdatavalid), 64'd0);
      check("rd_data_hold", 64'(bus.avm_readdata), 64'(exp));
    end
    settle_counts("rd");
  endtask

  initial begin
    logic [29:0] a;
    bit ok;
    bus.avm_address = '0;
    bus.avm_writedata = '0;
    bus.avm_byteenable = '0;
    bus.avm_burstcount = '0;
    bus.avm_write = 1'b0;
    bus.avm_read = 1'b0;
    bus.l15_ack = 1'b0;
    bus.l15_rsp_val = 1'b0;
    bus.l15_returntype = '0;
    bus.l15_data_0 = '0;
    bus.l15_data_1 = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_wait", 64'(bus.avm_waitrequest), 64'd1);
    check("rst_val", 64'(bus.l15_val), 64'd0);
    check("rst_rdv", 64'(bus.avm_readdatavalid), 64'd0);
    check("rst_rdata", 64'(bus.avm_readdata), 64'd0);
    check("rst_err", 64'(bus.err_pulse), 64'd0);
    check("rst_int", 64'(bus.int_pulse), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_wait", 64'(bus.avm_waitrequest), 64'd1);
    check("idle_val", 64'(bus.l15_val), 64'd0);

    do_read(30'h10, 1, 1, -1, 1'b1, 64'h11223344_55667788);
    do_write(30'h100, 4, 3, 4'hF, 1'b0);
    do_write(30'h200, 1, 0, 4'b1100, 1'b0);
    do_write(30'h200, 1, 1, 4'b0010, 1'b0);
    do_write(30'h200, 1, 2, 4'b0101, 1'b0);
    do_write(30'h204, 1, 0, 4'b0000, 1'b0);
    do_read(30'h3FFF_FFFF, 4, 0, -1, 1'b0, 64'd0);
    do_read(30'h40, 2, 2, 1, 1'b0, 64'd0);
    do_read(30'h41, 0, 1, 2, 1'b0, 64'd0);
    do_write(30'h80, 7, 0, 4'hF, 1'b0);
    do_read(30'h90, 6, 0, -1, 1'b0, 64'd0);

    for (int t = 0; t < 30; t++) begin
      a = $urandom_range(0, 1) ? 30'($urandom)
                               : 30'h3FFF_FFFC + 30'($urandom_range(0, 3));
      if ($urandom_range(0, 1))
        do_write(a, $urandom_range(0, 7), $urandom_range(0, 3),
                 4'h0, 1'b1);
      else
        do_read(a, $urandom_range(0, 7), $urandom_range(0, 3),
                $urandom_range(0, 2) == 0 ? $urandom_range(0, 3) : -1,
                1'b0, 64'd0);
    end

    bus.avm_read = 1'b1;
    bus.avm_address = 30'h123;
    bus.avm_burstcount = 3'd2;
    tick();
    bus.avm_read = 1'b0;
    wait_val(ok);
    bus.l15_ack = 1'b1;
    tick();
    bus.l15_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_val", 64'(bus.l15_val), 64'd0);
    check("mid_rst_wait", 64'(bus.avm_waitrequest), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    bus.l15_rsp_val = 1'b1;
    bus.l15_returntype = 4'b0000;
    bus.l15_data_0 = 64'hDEAD_BEEF_0BAD_F00D;
    #1;
    check("stale_req_ack", 64'(bus.l15_req_ack), 64'd1);
    check("stale_no_rdv", 64'(bus.avm_readdatavalid), 64'd0);
    tick();
    bus.l15_rsp_val = 1'b0;
    exp_err++;
    settle_counts("stale");
    check("stale_idle_val", 64'(bus.l15_val), 64'd0);
    check("stale_idle_wait", 64'(bus.avm_waitrequest), 64'd1);
    check("stale_rdata", 64'(bus.avm_readdata), 64'd0);

    do_read(30'h20, 1, 0, -1, 1'b0, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
